// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage and the decoder: write-data select,
// load funct3 values and the stage register layout.
// Ports: none (package only).
package wb_stage_pkg;

    // Write-data source select (in_wdsel)
    localparam logic [1:0] WDSEL_ALU = 2'b00;
    localparam logic [1:0] WDSEL_MEM = 2'b01;
    localparam logic [1:0] WDSEL_PC4 = 2'b10;
    localparam logic [1:0] WDSEL_IMM = 2'b11;

    // Load funct3 values (in_ldtype)
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // One MEM-stage result as held in the writeback register
    typedef struct packed {
        logic        regwrite;
        logic [4:0]  rd;
        logic [1:0]  wdsel;
        logic [31:0] alu;
        logic [31:0] mrdata;
        logic [2:0]  ldtype;
        logic [31:0] pc;
        logic [31:0] imm;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_fmt.sv
// Load formatter: extracts byte/half/word from an aligned memory word and extends it.
// Latency: purely combinational. Backpressure: none.
// Ports: rdata_i (raw word), off_i (byte offset), ldtype_i (funct3) -> data_o, misalign_o.
module wb_load_fmt
    import wb_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  ldtype_i,
    output logic [31:0] data_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (off_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        // Half is picked by off[1]; an odd offset is flagged below, not corrected.
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o     = 32'h0;
        misalign_o = 1'b0;
        case (ldtype_i)
            LD_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: data_o = {24'h0, byte_sel};
            LD_LH: begin
                data_o     = {{16{half_sel[15]}}, half_sel};
                misalign_o = off_i[0];
            end
            LD_LHU: begin
                data_o     = {16'h0, half_sel};
                misalign_o = off_i[0];
            end
            LD_LW: begin
                data_o     = rdata_i;
                misalign_o = (off_i != 2'd0);
            end
            // Unknown funct3: zero data and refuse the write.
            default: begin
                data_o     = 32'h0;
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers one MEM result, selects RF write data, drives RF port,
// a forwarding tap and a retired-instruction counter.
// Latency: accepted at edge N -> rf_wr/rf_wd valid during cycle N+1. Backpressure:
// in_ready = !valid_q || !wb_hold (full throughput when not held).
// Ports: clk/rst, in_* handshake and fields, wb_hold, rf_* write port, fwd_* tap,
// misalign_err pulse, instret counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_regwrite,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wdsel,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_mrdata,
    input  logic [2:0]       in_ldtype,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             wb_hold,
    output logic             rf_wr,
    output logic [4:0]       rf_a3,
    output logic [XLEN-1:0]  rf_wd,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             misalign_err,
    output logic [CNT_W-1:0] instret
);

    wb_entry_t        entry_q, entry_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic        transfer;
    logic        retire;
    logic [31:0] ld_data;
    logic        ld_misalign;
    logic        mem_misalign;
    logic [31:0] wd;

    assign in_ready = !valid_q || !wb_hold;
    assign transfer = in_valid && in_ready;
    // Gated by rst so an entry caught by reset never reaches the RF.
    assign retire   = valid_q && !wb_hold && !rst;

    always_comb begin
        entry_d = entry_q;
        if (transfer) begin
            entry_d.regwrite = in_regwrite;
            entry_d.rd       = in_rd;
            entry_d.wdsel    = in_wdsel;
            entry_d.alu      = in_alu;
            entry_d.mrdata   = in_mrdata;
            entry_d.ldtype   = in_ldtype;
            entry_d.pc       = in_pc;
            entry_d.imm      = in_imm;
        end
    end

    // A new transfer in the retire cycle keeps valid set and replaces the entry.
    always_comb begin
        valid_d = valid_q;
        if (transfer) begin
            valid_d = 1'b1;
        end else if (retire) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q   <= '0;
            valid_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            entry_q   <= entry_d;
            valid_q   <= valid_d;
            instret_q <= instret_d;
        end
    end

    wb_load_fmt u_load_fmt (
        .rdata_i    (entry_q.mrdata),
        .off_i      (entry_q.alu[1:0]),
        .ldtype_i   (entry_q.ldtype),
        .data_o     (ld_data),
        .misalign_o (ld_misalign)
    );

    // Load alignment only matters when the load result is the one being written.
    assign mem_misalign = (entry_q.wdsel == WDSEL_MEM) && ld_misalign;

    always_comb begin
        wd = entry_q.alu;
        case (entry_q.wdsel)
            WDSEL_ALU: wd = entry_q.alu;
            WDSEL_MEM: wd = ld_data;
            WDSEL_PC4: wd = entry_q.pc + 32'd4;
            WDSEL_IMM: wd = entry_q.imm;
            default:   wd = entry_q.alu;
        endcase
    end

    assign rf_wr        = retire && entry_q.regwrite && (entry_q.rd != 5'd0) && !mem_misalign;
    assign rf_a3        = entry_q.rd;
    assign rf_wd        = wd;
    assign fwd_valid    = rf_wr;
    assign fwd_rd       = entry_q.rd;
    assign fwd_data     = wd;
    assign misalign_err = retire && mem_misalign;
    assign instret      = instret_q;

endmodule
